gate_bist_checker: RTL and testbench

- Hardware counterpart of the gate-level stimulus benches: a built-in self-test controller for one 2-input switch-level gate.
- It drives the gate inputs through all four vectors {a,b} = 00, 01, 10, 11. After a programmable settle time it samples the gate output and compares it against a parameterised truth table.
- It reports pass/fail, a per-vector failure mask and an error count.
- It sits beside a CMOS gate instance (xnor, nand, nor, ...). The gate under test connects between a/b and c.

---
 rtl/gate_bist_checker_if.sv | 14 +
 rtl/gate_bist_checker.sv | 80 ++++++++
 tb/tb_gate_bist_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gate_bist_checker_if.sv
// gate_bist_checker_if: control, result and gate-pin bundle between the BIST checker and its environment.
interface gate_bist_checker_if;
    logic       start;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_vec;
    logic [2:0] err_cnt;
    modport master (output start, c, input a, b, busy, done, pass, fail_vec, err_cnt);
    modport slave  (input start, c, output a, b, busy, done, pass, fail_vec, err_cnt);
endinterface

// File: rtl/gate_bist_checker.sv
// gate_bist_checker: walks a 2-input gate through all four input vectors and checks c against TRUTH.
module gate_bist_checker #(
    parameter logic [3:0]  TRUTH  = 4'b1001,
    parameter int unsigned SETTLE = 2
) (
    input logic              clk,
    input logic              rst,
    gate_bist_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
    localparam logic [3:0] SET = 4'(SETTLE);
    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d, ab_q, ab_d;
    logic [3:0] cnt_q, cnt_d, fail_q, fail_d, fail_n;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d, miss;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ab_d    = ab_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        err_d   = err_q;
        pass_d  = pass_q;
        // X or Z on the gate output is a failure, hence the case inequality
        miss    = bus.c !== TRUTH[idx_q];
        fail_n  = fail_q | (4'(miss) << idx_q);
        if (state_q == HOLD) begin
            if (cnt_q != SET) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d  = 4'd0;
                fail_d = fail_n;
                err_d  = err_q + 3'(miss);
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    ab_d    = 2'd0;
                    pass_d  = fail_n == 4'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                    ab_d  = idx_q + 2'd1;
                end
            end
        end else if (bus.start) begin
            state_d = HOLD;
            idx_d   = 2'd0;
            ab_d    = 2'd0;
            cnt_d   = 4'd0;
            fail_d  = 4'd0;
            err_d   = 3'd0;
            pass_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            ab_q    <= 2'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 4'd0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ab_q    <= ab_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end
    assign bus.a        = ab_q[1];
    assign bus.b        = ab_q[0];
    assign bus.busy     = state_q == HOLD;
    assign bus.done     = state_q == DONE;
    assign bus.pass     = pass_q;
    assign bus.fail_vec = fail_q;
    assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb_gate_bist_checker: scoreboard bench driving modelled gates into a SETTLE=2 and a SETTLE=0 checker.
module tb_gate_bist_checker;
    localparam logic [3:0] TRUTH = 4'b1001;
    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       ps;
        int         lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    int   mode;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    gate_bist_checker_if u_if0 ();
    gate_bist_checker_if u_if1 ();
    gate_bist_checker #(.TRUTH(TRUTH), .SETTLE(2)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
    gate_bist_checker #(.TRUTH(TRUTH), .SETTLE(0)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
    // 0: XNOR, 1: stuck-at-0, 2: XOR, 3: XNOR with X while {a,b}=10
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a ^ b);
            1:       return 1'b0;
            2:       return a ^ b;
            default: return (a & ~b) ? 1'bx : ~(a ^ b);
        endcase
    endfunction
    assign u_if0.start = start & ~sel;
    assign u_if1.start = start & sel;
    assign u_if0.c     = gate(mode, u_if0.a, u_if0.b);
    assign u_if1.c     = gate(mode, u_if1.a, u_if1.b);
    logic       oa, ob, obusy, odone, opass;
    logic [3:0] ofv;
    logic [2:0] oec;
    assign oa    = sel ? u_if1.a        : u_if0.a;
    assign ob    = sel ? u_if1.b        : u_if0.b;
    assign obusy = sel ? u_if1.busy     : u_if0.busy;
    assign odone = sel ? u_if1.done     : u_if0.done;
    assign opass = sel ? u_if1.pass     : u_if0.pass;
    assign ofv   = sel ? u_if1.fail_vec : u_if0.fail_vec;
    assign oec   = sel ? u_if1.err_cnt  : u_if0.err_cnt;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_ab"}, int'({oa, ob}), 0);
        check({tag, "_busy"}, int'(obusy), 0);
        check({tag, "_done"}, int'(odone), 0);
        check({tag, "_pass"}, int'(opass), 0);
        check({tag, "_fv"}, int'(ofv), 0);
        check({tag, "_ec"}, int'(oec), 0);
    endtask
    // rk: loop step at which start is raised again mid-run (-1 for none)
    task automatic run_test(input logic s, input int m, input int rk);
        int st, k;
        exp_t e;
        logic [3:0] tr;
        sel  = s;
        mode = m;
        st   = s ? 0 : 2;
        tr   = TRUTH;
        e.fv = 4'd0;
        e.ec = 3'd0;
        for (int v = 0; v < 4; v++) begin
            if (gate(m, v[1], v[0]) !== tr[v]) begin
                e.fv[v] = 1'b1;
                e.ec    = e.ec + 3'd1;
            end
        end
        e.ps  = e.fv == 4'd0;
        e.lat = 4 * (st + 1);
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!odone && k < 40) begin
            check("ab_seq", int'({oa, ob}), k / (st + 1));
            check("busy_run", int'(obusy), 1);
            check("pass_run", int'(opass), 0);
            start = (k == rk);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check("latency", k, e.lat);
        check("fail_vec", int'(ofv), int'(e.fv));
        check("err_cnt", int'(oec), int'(e.ec));
        check("pass", int'(opass), int'(e.ps));
        check("done", int'(odone), 1);
        check("busy_done", int'(obusy), 0);
        check("ab_done", int'({oa, ob}), 0);
        @(negedge clk);
        check("hold_fv", int'(ofv), int'(e.fv));
        check("hold_done", int'(odone), 1);
    endtask
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check_idle("rst0");
        sel = 1'b1;
        check_idle("rst1");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");
        run_test(1'b0, 0, -1);
        run_test(1'b0, 1, -1);
        run_test(1'b0, 2, -1);
        run_test(1'b0, 3, -1);
        run_test(1'b1, 0, -1);
        run_test(1'b1, 2, -1);
        run_test(1'b0, 0, 4);
        sel   = 1'b0;
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", int'(obusy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        repeat (2) @(negedge clk);
        check("post_rst_busy", int'(obusy), 0);
        run_test(1'b0, 0, -1);
        run_test(1'b0, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
